// File: rtl/elevator_pkg.sv
// Shared elevator constants, scheduler state encoding and a floor-to-one-hot helper.
package elevator_pkg;
  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_UP   = 3'd1,
    SERVE_DOWN = 3'd2,
    DWELL      = 3'd3,
    EMERG      = 3'd4
  } sched_state_t;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] oh;
    oh    = '0;
    oh[f] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/call_debounce.sv
// One call-button bit: 2-flop synchronizer, then the level only changes after three
// consecutive agreeing samples.
module call_debounce (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic samp1_q, samp1_d;
  logic samp2_q, samp2_d;
  logic held_q,  held_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    samp1_d = sync2_q;
    samp2_d = samp1_q;
    held_d  = held_q;
    if (sync2_q && samp1_q && samp2_q)
      held_d = 1'b1;
    else if (!sync2_q && !samp1_q && !samp2_q)
      held_d = 1'b0;
  end

  // Clean level is taken combinationally so the filter adds four cycles, not five.
  assign btn_clean = held_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      samp1_q <= 1'b0;
      samp2_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp1_q <= samp1_d;
      samp2_q <= samp2_d;
      held_q  <= held_d;
    end
  end
endmodule

// File: rtl/floor_request_scheduler.sv
// Latches call buttons and steers the car with a collective up/down sweep and a timed dwell.
// Define FLOOR_SCHED_DEBOUNCE_EN to put call_debounce in front of the button edge detector.
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic                  emergency_stop,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  motor_stop,
  output logic [NUM_FLOORS-1:0] floor_req,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic [2:0]            state_dbg
);
  localparam logic [3:0] DWELL_LOAD = 4'(DWELL_CYCLES - 1);

  logic [NUM_FLOORS-1:0] btn_lvl;

`ifdef FLOOR_SCHED_DEBOUNCE_EN
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_deb
    call_debounce u_call_debounce (
      .clk       (clk),
      .rst       (reset),
      .btn_raw   (call_btn[gi]),
      .btn_clean (btn_lvl[gi])
    );
  end
`else
  assign btn_lvl = call_btn;
`endif

  sched_state_t          state_q,     state_d;
  logic [NUM_FLOORS-1:0] btn_hist_q,  btn_hist_d;
  logic [NUM_FLOORS-1:0] pending_q,   pending_d;
  logic [FLOOR_W-1:0]    target_q,    target_d;
  logic                  last_up_q,   last_up_d;
  logic [3:0]            dwell_cnt_q, dwell_cnt_d;
  logic [NUM_FLOORS-1:0] floor_req_q, floor_req_d;
  logic                  door_open_q, door_open_d;
  logic                  dir_up_q,    dir_up_d;

  logic                  up_hit, dn_hit, here_hit;
  logic [FLOOR_W-1:0]    up_tgt, dn_tgt;
  logic [NUM_FLOORS-1:0] clear_mask;

  // Descending scan leaves the lowest floor above; ascending scan leaves the highest below.
  always_comb begin
    up_hit = 1'b0;
    up_tgt = '0;
    dn_hit = 1'b0;
    dn_tgt = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (i > int'(current_floor))) begin
        up_hit = 1'b1;
        up_tgt = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (i < int'(current_floor))) begin
        dn_hit = 1'b1;
        dn_tgt = FLOOR_W'(i);
      end
    end
    here_hit = pending_q[current_floor];
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    last_up_d   = last_up_q;
    dwell_cnt_d = dwell_cnt_q;
    if (emergency_stop) begin
      state_d = EMERG;
    end else begin
      case (state_q)
        IDLE: begin
          if (here_hit) begin
            state_d = DWELL;
          end else if (up_hit) begin
            state_d   = SERVE_UP;
            target_d  = up_tgt;
            last_up_d = 1'b1;
          end else if (dn_hit) begin
            state_d   = SERVE_DOWN;
            target_d  = dn_tgt;
            last_up_d = 1'b0;
          end
        end
        SERVE_UP: begin
          // Once level with the target, hold it until the controller reports a stop.
          if (current_floor == target_q) begin
            if (motor_stop) state_d = DWELL;
          end else if (up_hit) begin
            target_d = up_tgt;
          end else begin
            state_d = IDLE;
          end
        end
        SERVE_DOWN: begin
          if (current_floor == target_q) begin
            if (motor_stop) state_d = DWELL;
          end else if (dn_hit) begin
            target_d = dn_tgt;
          end else begin
            state_d = IDLE;
          end
        end
        DWELL: begin
          if (dwell_cnt_q != 4'd0) begin
            dwell_cnt_d = dwell_cnt_q - 4'd1;
          end else if ((last_up_q && up_hit) || (!last_up_q && !dn_hit && up_hit)) begin
            state_d   = SERVE_UP;
            target_d  = up_tgt;
            last_up_d = 1'b1;
          end else if (dn_hit) begin
            state_d   = SERVE_DOWN;
            target_d  = dn_tgt;
            last_up_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        EMERG:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if ((state_d == DWELL) && (state_q != DWELL))
      dwell_cnt_d = DWELL_LOAD;
  end

  // While the door is (or is about to be) open here, a press at this floor is already served.
  always_comb begin
    clear_mask  = (state_d == DWELL) ? floor_onehot(current_floor) : '0;
    btn_hist_d  = btn_lvl;
    pending_d   = (pending_q | (btn_lvl & ~btn_hist_q)) & ~clear_mask;
    floor_req_d = '0;
    if ((state_d == SERVE_UP) || (state_d == SERVE_DOWN))
      floor_req_d = floor_onehot(target_d);
    door_open_d = (state_d == DWELL);
    dir_up_d    = (state_d == SERVE_UP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      btn_hist_q  <= '0;
      pending_q   <= '0;
      target_q    <= '0;
      last_up_q   <= 1'b1;
      dwell_cnt_q <= 4'd0;
      floor_req_q <= '0;
      door_open_q <= 1'b0;
      dir_up_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_hist_q  <= btn_hist_d;
      pending_q   <= pending_d;
      target_q    <= target_d;
      last_up_q   <= last_up_d;
      dwell_cnt_q <= dwell_cnt_d;
      floor_req_q <= floor_req_d;
      door_open_q <= door_open_d;
      dir_up_q    <= dir_up_d;
    end
  end

  assign floor_req = floor_req_q;
  assign door_open = door_open_q;
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;
  assign state_dbg = state_q;
endmodule

// File: doc/floor_request_scheduler.md
FLOOR_REQUEST_SCHEDULER -- requirements
Module: floor_request_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4, door-open hold time in clocks (legal 1..15).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port call_btn  input  4  raw cab/hall call buttons, bit i = floor i, level-high while pressed.
REQ-005 SHALL have port emergency_stop  input  1  level-high emergency, shared with elevator controller.
REQ-006 SHALL have port current_floor  input  2  floor reported by downstream controller.
REQ-007 SHALL have port motor_stop  input  1  controller reports car stationary.
REQ-008 SHALL have port floor_req  output  4  registered one-hot target to controller; all-zero = no request.
REQ-009 SHALL have port door_open  output  1  registered, high during dwell.
REQ-010 SHALL have port pending  output  4  registered latched-call vector.
REQ-011 SHALL have port dir_up  output  1  registered, high while in SERVE_UP.

Function
REQ-012 SHALL set pending[i] on the rising edge of call_btn[i] (high now, low previous sample); held buttons SHALL set once only.
REQ-013 SHALL clear pending[i] on entry to DWELL at floor i; same-cycle set and clear on that floor: clear wins.
REQ-014 SHALL implement states IDLE, SERVE_UP, SERVE_DOWN, DWELL, EMERG.
REQ-015 IDLE: pending[current_floor] -> DWELL; else any pending above -> SERVE_UP; else any below -> SERVE_DOWN; above and below both pending -> SERVE_UP.
REQ-016 SERVE_UP target SHALL be the lowest pending floor strictly above current_floor; SERVE_DOWN the highest strictly below; target re-evaluated each cycle, so new nearer calls are picked up en route.
REQ-017 floor_req SHALL be onehot(target) in SERVE_UP/SERVE_DOWN, zero in IDLE, DWELL, EMERG; never more than one bit set.
REQ-018 Arrival: current_floor == target and motor_stop == 1 -> DWELL.
REQ-019 DWELL SHALL hold door_open high exactly DWELL_CYCLES cycles, then: pending in previous direction -> continue; else pending opposite -> reverse; else IDLE.
REQ-020 emergency_stop high SHALL force EMERG on the next edge from any state, aborting dwell; pending SHALL be retained and SHALL keep latching new calls.
REQ-021 EMERG -> IDLE one cycle after emergency_stop deasserts.
REQ-022 Latency: press sampled at edge k -> pending set after edge k -> floor_req valid after edge k+1 (from IDLE).
REQ-023 Dwell counter SHALL be 4 bits, saturating, reloaded on each DWELL entry.

Reset
REQ-024 reset SHALL asynchronously force state IDLE, pending 0, floor_req 0, door_open 0, dir_up 0, dwell counter 0, button edge history 0.
REQ-025 reset mid-travel or mid-dwell SHALL discard all calls; no request SHALL survive reset.

Configuration
REQ-026 With FLOOR_SCHED_DEBOUNCE_EN defined, each call_btn bit SHALL pass a 2-flop synchronizer plus 3-consecutive-sample debounce before edge detection, adding 4 cycles press latency.
REQ-027 Without FLOOR_SCHED_DEBOUNCE_EN, call_btn SHALL feed edge detection directly (single history flop).

Structure
REQ-028 Package elevator_pkg SHALL hold NUM_FLOORS = 4, FLOOR_W = 2, and the scheduler state enum.
REQ-029 Target selection (lowest-above / highest-below search) SHALL be combinational in this module; the optional debouncer SHALL be sub-module call_debounce, instantiated per bit.

Verification
REQ-030 Reset, current_floor 0, pulse call_btn 4'b1000 one cycle -> pending 4'b1000 next cycle, floor_req 4'b1000 and dir_up 1 the cycle after.
REQ-031 En route at floor 1 heading to 3, press floor 2 -> floor_req switches to 4'b0100; arrival at 2 with motor_stop -> door_open high 4 cycles, then floor_req 4'b1000.
REQ-032 At floor 3 idle, pending 4'b0011 -> SERVE_DOWN, floor_req 4'b0010 then 4'b0001 after dwell at 1.
REQ-033 Mid-SERVE_UP assert emergency_stop 3 cycles -> floor_req 0 next cycle, pending unchanged; release -> IDLE then floor_req resumes same target.
REQ-034 Call at current floor while IDLE (floor 2, press 4'b0100) -> DWELL, pending[2] cleared, floor_req stays 0; press same button during dwell -> not relatched.
REQ-035 Assert reset during DWELL with pending 4'b1010 -> all outputs 0 immediately, pending 0.
